hazard_forward_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline: IF / ID / EX / MEM / WB, with a side multi-cycle (mul/div) unit.
- Generates per-operand ALU forwarding selects for any number of source operands and forwarding stages.
- Detects load-use hazards.
- Tracks one outstanding multi-cycle operation with a countdown scoreboard and stalls dependent or conflicting instructions in ID.

---
 rtl/hazard_forward_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage in-order pipeline with a side mul/div unit.
// Optional stall performance counters are compiled in with HAZ_PERF_CNT_EN.

module hazard_forward_lane #(
  parameter int NUM_FWD = 2,
  parameter int RA_W    = 5,
  parameter int SEL_W   = 2
) (
  input  logic [RA_W-1:0]         ex_rs,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [RA_W-1:0]         id_rs,
  input  logic                    id_used,
  input  logic [RA_W-1:0]         ex_rd,
  input  logic [RA_W-1:0]         pend_rd,
  output logic [SEL_W-1:0]        sel,
  output logic                    hit_ex,
  output logic                    hit_pend
);
  // Scan from the farthest stage down so the nearest match is written last and wins.
  always_comb begin
    sel = '0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_rd[k*RA_W +: RA_W] != '0) && (fwd_rd[k*RA_W +: RA_W] == ex_rs))
        sel = SEL_W'(k+1);
    end
  end

  assign hit_ex   = id_used && (ex_rd != '0)   && (id_rs == ex_rd);
  assign hit_pend = id_used && (pend_rd != '0) && (id_rs == pend_rd);
endmodule

module hazard_forward_ctrl #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int RA_W    = 5,
  parameter int MC_LAT  = 4,
  parameter int SEL_W   = $clog2(NUM_FWD+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC*RA_W-1:0] ex_rs,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_we,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  input  logic [NUM_SRC*RA_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]      id_src_used,
  input  logic                    id_is_mc,
  input  logic                    ex_valid,
  input  logic [RA_W-1:0]         ex_rd,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  input  logic                    ex_is_mc,
  output logic                    stall_id,
  output logic                    bubble_ex,
  output logic                    mc_busy,
  output logic [RA_W-1:0]         mc_rd_pend
`ifdef HAZ_PERF_CNT_EN
  ,
  input  logic                    perf_clr,
  output logic [31:0]             perf_lu_stalls,
  output logic [31:0]             perf_mc_stalls
`endif
);
  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [NUM_SRC-1:0] hit_ex, hit_pend;
  logic load_use, haz_a, haz_b, haz_c, mc_issue;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    hazard_forward_lane #(.NUM_FWD(NUM_FWD), .RA_W(RA_W), .SEL_W(SEL_W)) u_lane (
      .ex_rs    (ex_rs[i*RA_W +: RA_W]),
      .fwd_rd   (fwd_rd),
      .fwd_we   (fwd_we),
      .id_rs    (id_rs[i*RA_W +: RA_W]),
      .id_used  (id_src_used[i]),
      .ex_rd    (ex_rd),
      .pend_rd  (mc_rd_pend),
      .sel      (fwd_sel[i*SEL_W +: SEL_W]),
      .hit_ex   (hit_ex[i]),
      .hit_pend (hit_pend[i])
    );
  end

  assign mc_issue  = ex_valid && ex_is_mc;
  assign load_use  = ex_valid && ex_mem_read && ex_reg_write && (|hit_ex);
  assign haz_a     = mc_issue && ex_reg_write && (|hit_ex);
  assign haz_b     = mc_busy && (|hit_pend);
  assign haz_c     = id_is_mc && (mc_busy || mc_issue);
  assign stall_id  = load_use || haz_a || haz_b || haz_c;
  assign bubble_ex = stall_id;

  // mc_busy drops on the edge cnt reaches 0; the FSM spends that last cycle in BUSY
  // so a dependent released then never meets a half-finished unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mc_busy    <= 1'b0;
      mc_rd_pend <= '0;
    end else begin
      case (state)
        IDLE: if (mc_issue) begin
          state      <= BUSY;
          cnt        <= CNT_W'(MC_LAT-1);
          mc_busy    <= 1'b1;
          mc_rd_pend <= ex_reg_write ? ex_rd : '0;
        end
        BUSY: if (cnt == '0) begin
          state      <= IDLE;
          mc_rd_pend <= '0;
        end else begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) mc_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      perf_lu_stalls <= '0;
      perf_mc_stalls <= '0;
    end else begin
      if (load_use && (perf_lu_stalls != 32'hFFFF_FFFF))
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if (stall_id && !load_use && (perf_mc_stalls != 32'hFFFF_FFFF))
        perf_mc_stalls <= perf_mc_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed plus randomized bench for hazard_forward_ctrl against a cycle-indexed reference model.
module tb_hazard_forward_ctrl;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int RA_W    = 5;
  localparam int MC_LAT  = 4;
  localparam int SEL_W   = $clog2(NUM_FWD+1);

  logic clk = 1'b0;
  logic reset;
  logic [NUM_SRC*RA_W-1:0]  ex_rs, id_rs;
  logic [NUM_FWD*RA_W-1:0]  fwd_rd;
  logic [NUM_FWD-1:0]       fwd_we;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [NUM_SRC-1:0]       id_src_used;
  logic id_is_mc, ex_valid, ex_reg_write, ex_mem_read, ex_is_mc;
  logic [RA_W-1:0] ex_rd, mc_rd_pend;
  logic stall_id, bubble_ex, mc_busy;

  hazard_forward_ctrl #(.NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .RA_W(RA_W), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .reset(reset), .ex_rs(ex_rs), .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_sel(fwd_sel),
    .id_rs(id_rs), .id_src_used(id_src_used), .id_is_mc(id_is_mc), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mc(ex_is_mc),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .mc_busy(mc_busy), .mc_rd_pend(mc_rd_pend)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  int cyc = 0;
  int issue_cyc = -100;
  int pend_m = 0;

  // Reference: an op issued in cycle t keeps the unit busy in cycles t+1..t+MC_LAT-1
  // and the unit accepts a new op from cycle t+MC_LAT+1.
  function automatic bit m_busy();
    return (cyc > issue_cyc) && (cyc < issue_cyc + MC_LAT);
  endfunction
  function automatic bit m_idle();
    return cyc > issue_cyc + MC_LAT;
  endfunction

  function automatic int exp_sel(int i);
    int rs;
    rs = int'(ex_rs[i*RA_W +: RA_W]);
    for (int k = 0; k < NUM_FWD; k++)
      if (fwd_we[k] && fwd_rd[k*RA_W +: RA_W] != 0 && int'(fwd_rd[k*RA_W +: RA_W]) == rs)
        return k + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lu, a, b, c;
    int r;
    lu = 0; a = 0; b = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      r = int'(id_rs[i*RA_W +: RA_W]);
      if (id_src_used[i]) begin
        if (ex_valid && ex_mem_read && ex_reg_write && ex_rd != 0 && r == int'(ex_rd)) lu = 1;
        if (ex_valid && ex_is_mc && ex_reg_write && ex_rd != 0 && r == int'(ex_rd)) a = 1;
        if (m_busy() && pend_m != 0 && r == pend_m) b = 1;
      end
    end
    c = id_is_mc && (m_busy() || (ex_valid && ex_is_mc));
    return lu || a || b || c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NUM_SRC; i++)
      chk($sformatf("%s.sel%0d", tag, i), 32'(fwd_sel[i*SEL_W +: SEL_W]), 32'(exp_sel(i)));
    chk({tag, ".stall"}, 32'(stall_id), 32'(exp_stall()));
    chk({tag, ".bubble"}, 32'(bubble_ex), 32'(exp_stall()));
    chk({tag, ".busy"}, 32'(mc_busy), 32'(m_busy()));
    if (m_busy()) chk({tag, ".pend"}, 32'(mc_rd_pend), 32'(pend_m));
  endtask

  // Advance one clock, updating the reference with what the DUT sees at this edge.
  task automatic tick();
    if (reset) begin
      issue_cyc = -100;
      pend_m = 0;
    end else if (ex_valid && ex_is_mc && m_idle()) begin
      issue_cyc = cyc;
      pend_m = ex_reg_write ? int'(ex_rd) : 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_in();
    ex_rs = '0; id_rs = '0; fwd_rd = '0; fwd_we = '0; id_src_used = '0;
    id_is_mc = 0; ex_valid = 0; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0; ex_is_mc = 0;
  endtask

  task automatic ex_mc(input int rd);
    ex_valid = 1; ex_is_mc = 1; ex_reg_write = 1; ex_mem_read = 0; ex_rd = RA_W'(rd);
  endtask

  initial begin
    clear_in();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst.busy", 32'(mc_busy), 0);
    chk("rst.pend", 32'(mc_rd_pend), 0);
    chk("rst.stall", 32'(stall_id), 0);
    chk("rst.sel", 32'(fwd_sel), 0);

    // Forwarding priority and x0
    ex_rs[0 +: RA_W] = 5; fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11; #1;
    chk("fwd.near", 32'(fwd_sel[0 +: SEL_W]), 1);
    fwd_we = 2'b10; #1;
    chk("fwd.wb", 32'(fwd_sel[0 +: SEL_W]), 2);
    ex_rs[RA_W +: RA_W] = 0; fwd_rd[0 +: RA_W] = 0; fwd_we = 2'b11; #1;
    chk("fwd.x0", 32'(fwd_sel[SEL_W +: SEL_W]), 0);
    tick(); clear_in();

    // Load-use: lw x7 in EX, add x8,x7,x3 in ID
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7;
    id_rs = {5'd3, 5'd7}; id_src_used = 2'b11; #1;
    chk("lu.stall", 32'(stall_id), 1);
    chk("lu.bubble", 32'(bubble_ex), 1);
    tick();
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; #1;
    chk("lu.release", 32'(stall_id), 0);
    tick();
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_src_used = 2'b00; #1;
    chk("lu.unused", 32'(stall_id), 0);
    tick(); clear_in();

    // Multi-cycle RAW: mul x9, consumer of x9 stalls MC_LAT cycles
    ex_mc(9); id_rs[0 +: RA_W] = 9; id_src_used = 2'b01; #1;
    chk("raw.issue_stall", 32'(stall_id), 1);
    tick();
    ex_valid = 0; ex_is_mc = 0; ex_reg_write = 0;
    for (int n = 0; n < MC_LAT-1; n++) begin
      #1;
      chk("raw.busy", 32'(mc_busy), 1);
      chk("raw.pend", 32'(mc_rd_pend), 9);
      chk("raw.stall", 32'(stall_id), 1);
      tick();
    end
    #1;
    chk("raw.busy_fall", 32'(mc_busy), 0);
    chk("raw.released", 32'(stall_id), 0);
    tick(); clear_in(); tick();

    // Structural: second mul waits in ID; an illegal issue during BUSY is ignored
    ex_mc(10); id_is_mc = 1; #1;
    chk("st.issue", 32'(stall_id), 1);
    tick();
    ex_mc(12); #1;
    chk("st.illegal_stall", 32'(stall_id), 1);
    tick();
    ex_valid = 0; ex_is_mc = 0; ex_reg_write = 0;
    for (int n = 0; n < MC_LAT-2; n++) begin
      #1;
      chk("st.busy", 32'(mc_busy), 1);
      chk("st.pend", 32'(mc_rd_pend), 10);
      chk("st.stall", 32'(stall_id), 1);
      tick();
    end
    #1;
    chk("st.busy_fall", 32'(mc_busy), 0);
    chk("st.go", 32'(stall_id), 0);
    tick();
    id_is_mc = 0; ex_mc(11);
    tick();
    ex_valid = 0; ex_is_mc = 0; #1;
    chk("st.second_busy", 32'(mc_busy), 1);
    chk("st.second_pend", 32'(mc_rd_pend), 11);
    repeat (MC_LAT) tick();
    clear_in(); tick();

    // Reset while BUSY with cnt=2
    ex_mc(13); tick();
    ex_valid = 0; ex_is_mc = 0; ex_reg_write = 0;
    id_rs[0 +: RA_W] = 13; id_src_used = 2'b01;
    tick();
    reset = 1; tick();
    reset = 0; #1;
    chk("rstb.busy", 32'(mc_busy), 0);
    chk("rstb.pend", 32'(mc_rd_pend), 0);
    chk("rstb.stall", 32'(stall_id), 0);
    tick(); clear_in();

    // Randomized phase against the reference model
    for (int n = 0; n < 400; n++) begin
      ex_rs        = {RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7))};
      id_rs        = {RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7))};
      fwd_rd       = {RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7))};
      fwd_we       = NUM_FWD'($urandom);
      id_src_used  = NUM_SRC'($urandom);
      id_is_mc     = ($urandom_range(0, 3) == 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_rd        = RA_W'($urandom_range(0, 7));
      ex_reg_write = $urandom_range(0, 1) == 1;
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_is_mc     = m_idle() && ($urandom_range(0, 3) == 0);
      #1;
      check_model("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
